// File: rtl/display_scanner.sv
// display_scanner: time-multiplexes a hex value onto one 7-segment decoder with digit enables,
// dead-time between digits, frame-synchronous value commit and optional leading-zero blanking.
module display_scanner #(
    parameter int N_DIGITS       = 4,
    parameter int DIV            = 27000,
    parameter int GAP            = 64,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic [4*N_DIGITS-1:0] i_value,
    input  logic                  i_lz_en,
    output logic [3:0]            o_nibble,
    output logic                  o_seg_blank,
    output logic [N_DIGITS-1:0]   o_dig,
    output logic                  o_frame,
    output logic                  o_pending
);
    localparam int IW   = $clog2(N_DIGITS);
    localparam int CMAX = DIV > GAP ? DIV : GAP;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [N_DIGITS-1:0] DIG_OFF = {N_DIGITS{DIG_ACTIVE_LOW}};

    typedef enum logic {S_SHOW, S_GAP} state_t;

    state_t                r_state, w_state_nx;
    logic [CW-1:0]         r_cnt, w_cnt_nx;
    logic [IW-1:0]         r_idx, w_idx_nx;
    logic [4*N_DIGITS-1:0] r_disp, r_pend;
    logic                  r_pending;
    logic                  w_wrap;
    logic                  w_hi_zero;
    logic [N_DIGITS-1:0]   w_onehot;

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt + 1'b1;
        w_idx_nx   = r_idx;
        w_wrap     = 1'b0;
        if (r_state == S_SHOW) begin
            if (r_cnt == CW'(DIV - 1)) begin
                w_state_nx = S_GAP;
                w_cnt_nx   = '0;
            end
        end else if (r_cnt == CW'(GAP - 1)) begin
            w_state_nx = S_SHOW;
            w_cnt_nx   = '0;
            w_wrap     = r_idx == IW'(N_DIGITS - 1);
            w_idx_nx   = w_wrap ? '0 : r_idx + 1'b1;
        end
    end

    // w_hi_zero: current digit and every more-significant digit are zero
    always_comb begin
        w_hi_zero = 1'b1;
        for (int j = 0; j < N_DIGITS; j++)
            if (j >= int'(r_idx) && r_disp[4*j +: 4] != 4'd0) w_hi_zero = 1'b0;
        w_onehot        = '0;
        w_onehot[r_idx] = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_SHOW;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_disp      <= '0;
            r_pend      <= '0;
            r_pending   <= 1'b0;
            o_nibble    <= 4'd0;
            o_seg_blank <= 1'b1;
            o_dig       <= DIG_OFF;
            o_frame     <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_idx   <= w_idx_nx;
            o_frame <= w_wrap;
            // a LOAD coinciding with the commit bypasses the pending register
            if (w_wrap) begin
                if (i_load) r_disp <= i_value;
                else if (r_pending) r_disp <= r_pend;
                r_pending <= 1'b0;
            end else if (i_load) begin
                r_pend    <= i_value;
                r_pending <= 1'b1;
            end
            if (r_state == S_SHOW) begin
                o_dig       <= w_onehot ^ DIG_OFF;
                o_nibble    <= r_disp[{r_idx, 2'b00} +: 4];
                o_seg_blank <= i_lz_en && r_idx != '0 && w_hi_zero;
            end else begin
                o_dig       <= DIG_OFF;
                o_seg_blank <= 1'b1;
            end
        end
    end

    assign o_pending = r_pending;
endmodule

// File: tb/tb_display_scanner.sv
// tb_display_scanner: randomized scenarios checked against a time-arithmetic model of the scanner,
// run on active-low and active-high digit-enable instances side by side.
module tb_display_scanner;
    localparam int N = 4, DIV = 4, GAP = 2, P = DIV + GAP, FP = N * P;

    logic        clk = 1'b0, rst = 1'b1, load = 1'b0, lz = 1'b0;
    logic [15:0] value = 16'h0;
    logic [3:0]  nib_l, nib_h, dig_l, dig_h;
    logic        blank_l, blank_h, frame_l, frame_h, pend_l, pend_h;

    int          checks = 0, errors = 0, k = 0;
    logic [15:0] m_disp, m_pend;
    logic        m_pending, m_blank, m_frame;
    logic [3:0]  m_nib, m_dig;

    always #5 clk = ~clk;

    display_scanner #(.N_DIGITS(N), .DIV(DIV), .GAP(GAP), .DIG_ACTIVE_LOW(1'b1)) dut_l (
        .i_clk(clk), .i_rst(rst), .i_load(load), .i_value(value), .i_lz_en(lz),
        .o_nibble(nib_l), .o_seg_blank(blank_l), .o_dig(dig_l), .o_frame(frame_l), .o_pending(pend_l));

    display_scanner #(.N_DIGITS(N), .DIV(DIV), .GAP(GAP), .DIG_ACTIVE_LOW(1'b0)) dut_h (
        .i_clk(clk), .i_rst(rst), .i_load(load), .i_value(value), .i_lz_en(lz),
        .o_nibble(nib_h), .o_seg_blank(blank_h), .o_dig(dig_h), .o_frame(frame_h), .o_pending(pend_h));

    // k counts cycles since reset release; each cycle's state follows from k by division
    task automatic step();
        int idx;
        bit show;
        @(posedge clk);
        if (rst) begin
            k = 0; m_disp = 0; m_pend = 0; m_pending = 0;
            m_nib = 0; m_blank = 1; m_dig = 0; m_frame = 0;
        end else begin
            idx  = (k / P) % N;
            show = (k % P) < DIV;
            if (show) begin
                m_dig   = 4'(1 << idx);
                m_nib   = m_disp[4*idx +: 4];
                m_blank = lz && idx > 0 && (m_disp >> (4 * idx)) == 0;
            end else begin
                m_dig   = 0;
                m_blank = 1;
            end
            m_frame = (k % FP) == FP - 1;
            if (m_frame) begin
                if (load) m_disp = value;
                else if (m_pending) m_disp = m_pend;
                m_pending = 0;
            end else if (load) begin
                m_pend    = value;
                m_pending = 1;
            end
            k++;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1;
        step();
        step();
        checks++;
        if ({dig_l, dig_h, nib_l, nib_h, blank_l, blank_h, frame_l, frame_h, pend_l, pend_h} !==
            {4'hF, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset: got dig %h/%h nib %h/%h blank %b/%b frame %b/%b pend %b/%b, want dig F/0 nib 0 blank 1 frame 0 pend 0",
                     dig_l, dig_h, nib_l, nib_h, blank_l, blank_h, frame_l, frame_h, pend_l, pend_h);
        end
    endtask

    task automatic test_scan();
        rst = 0;
        repeat (2 * FP + 2) begin
            step();
            checks++;
            if ({dig_l, dig_h, nib_l, nib_h, blank_l, blank_h, frame_l, frame_h, pend_l, pend_h} !==
                {~m_dig, m_dig, m_nib, m_nib, m_blank, m_blank, m_frame, m_frame, m_pending, m_pending}) begin
                errors++;
                $display("FAIL scan k=%0d: got dig %h/%h nib %h/%h blank %b/%b frame %b/%b pend %b/%b, want dig %h nib %h blank %b frame %b pend %b",
                         k, dig_l, dig_h, nib_l, nib_h, blank_l, blank_h, frame_l, frame_h, pend_l, pend_h, m_dig, m_nib, m_blank, m_frame, m_pending);
            end
        end
    endtask

    task automatic test_load();
        while (k % FP != 7) step();
        load = 1;
        value = 16'h1A3F;
        step();
        load = 0;
        value = 16'(($urandom));
        checks++;
        if (pend_l !== 1'b1 || pend_h !== 1'b1) begin
            errors++;
            $display("FAIL load_pending: got %b/%b, want 1", pend_l, pend_h);
        end
        repeat (2 * FP) begin
            step();
            value = 16'($urandom);
            checks++;
            if ({dig_l, dig_h, nib_l, nib_h, blank_l, blank_h, frame_l, frame_h, pend_l, pend_h} !==
                {~m_dig, m_dig, m_nib, m_nib, m_blank, m_blank, m_frame, m_frame, m_pending, m_pending}) begin
                errors++;
                $display("FAIL load k=%0d: got dig %h/%h nib %h/%h blank %b/%b frame %b/%b pend %b/%b, want dig %h nib %h blank %b frame %b pend %b",
                         k, dig_l, dig_h, nib_l, nib_h, blank_l, blank_h, frame_l, frame_h, pend_l, pend_h, m_dig, m_nib, m_blank, m_frame, m_pending);
            end
        end
    endtask

    task automatic test_lz();
        logic [15:0] vals [2] = '{16'h0050, 16'h0000};
        lz = 1;
        foreach (vals[v]) begin
            while (k % FP != 3) step();
            load = 1;
            value = vals[v];
            step();
            load = 0;
            repeat (2 * FP) begin
                step();
                checks++;
                if ({dig_l, dig_h, nib_l, nib_h, blank_l, blank_h, frame_l, frame_h, pend_l, pend_h} !==
                    {~m_dig, m_dig, m_nib, m_nib, m_blank, m_blank, m_frame, m_frame, m_pending, m_pending}) begin
                    errors++;
                    $display("FAIL lz value=%h k=%0d: got dig %h/%h nib %h/%h blank %b/%b frame %b/%b pend %b/%b, want dig %h nib %h blank %b frame %b pend %b",
                             vals[v], k, dig_l, dig_h, nib_l, nib_h, blank_l, blank_h, frame_l, frame_h, pend_l, pend_h, m_dig, m_nib, m_blank, m_frame, m_pending);
                end
            end
        end
        lz = 0;
    endtask

    task automatic test_commit_load();
        while (k % FP != 5) step();
        load = 1;
        value = 16'hFFFF;
        step();
        load = 0;
        while (k % FP != FP - 1) step();
        load = 1;
        value = 16'h1234;
        step();
        load = 0;
        checks++;
        if (pend_l !== 1'b0 || pend_h !== 1'b0 || frame_l !== 1'b1 || frame_h !== 1'b1) begin
            errors++;
            $display("FAIL commit_load: got pend %b/%b frame %b/%b, want pend 0 frame 1", pend_l, pend_h, frame_l, frame_h);
        end
        repeat (2 * FP) begin
            step();
            checks++;
            if ({dig_l, dig_h, nib_l, nib_h, blank_l, blank_h, frame_l, frame_h, pend_l, pend_h} !==
                {~m_dig, m_dig, m_nib, m_nib, m_blank, m_blank, m_frame, m_frame, m_pending, m_pending}) begin
                errors++;
                $display("FAIL commit_load k=%0d: got dig %h/%h nib %h/%h blank %b/%b frame %b/%b pend %b/%b, want dig %h nib %h blank %b frame %b pend %b",
                         k, dig_l, dig_h, nib_l, nib_h, blank_l, blank_h, frame_l, frame_h, pend_l, pend_h, m_dig, m_nib, m_blank, m_frame, m_pending);
            end
        end
    endtask

    task automatic test_reset_mid();
        while (k % FP != 3) step();
        load = 1;
        value = 16'($urandom_range(1, 16'hFFFF));
        step();
        load = 0;
        while (k % FP != 2 * P + 1) step();
        rst = 1;
        step();
        checks++;
        if ({dig_l, dig_h, nib_l, nib_h, blank_l, blank_h, frame_l, frame_h, pend_l, pend_h} !==
            {4'hF, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid: got dig %h/%h nib %h/%h blank %b/%b frame %b/%b pend %b/%b, want dig F/0 nib 0 blank 1 frame 0 pend 0",
                     dig_l, dig_h, nib_l, nib_h, blank_l, blank_h, frame_l, frame_h, pend_l, pend_h);
        end
        rst = 0;
        repeat (FP + 2) begin
            step();
            checks++;
            if ({dig_l, dig_h, nib_l, nib_h, blank_l, blank_h, frame_l, frame_h, pend_l, pend_h} !==
                {~m_dig, m_dig, m_nib, m_nib, m_blank, m_blank, m_frame, m_frame, m_pending, m_pending}) begin
                errors++;
                $display("FAIL reset_mid k=%0d: got dig %h/%h nib %h/%h blank %b/%b frame %b/%b pend %b/%b, want dig %h nib %h blank %b frame %b pend %b",
                         k, dig_l, dig_h, nib_l, nib_h, blank_l, blank_h, frame_l, frame_h, pend_l, pend_h, m_dig, m_nib, m_blank, m_frame, m_pending);
            end
        end
    endtask

    task automatic test_random();
        repeat (600) begin
            load  = ($urandom_range(0, 9) == 0);
            value = $urandom_range(0, 3) == 0 ? 16'($urandom_range(0, 255)) : 16'($urandom);
            lz    = ($urandom_range(0, 7) != 0) ? lz : ~lz;
            step();
            checks++;
            if ({dig_l, dig_h, nib_l, nib_h, blank_l, blank_h, frame_l, frame_h, pend_l, pend_h} !==
                {~m_dig, m_dig, m_nib, m_nib, m_blank, m_blank, m_frame, m_frame, m_pending, m_pending}) begin
                errors++;
                $display("FAIL random k=%0d: got dig %h/%h nib %h/%h blank %b/%b frame %b/%b pend %b/%b, want dig %h nib %h blank %b frame %b pend %b",
                         k, dig_l, dig_h, nib_l, nib_h, blank_l, blank_h, frame_l, frame_h, pend_l, pend_h, m_dig, m_nib, m_blank, m_frame, m_pending);
            end
        end
        load = 0;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load();
        test_lz();
        test_commit_load();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/display_scanner.md
Name: display_scanner

Overview:
- Time-multiplexes a multi-digit hex value onto one shared 7-segment decoder and a bank of common-anode/cathode digit enables.
- Sits directly upstream of the 7-segment decoder: drives its 4-bit nibble input (NIBBLE[3] → MSB input, NIBBLE[0] → LSB input) and qualifies its output with a blank flag.
- Provides tear-free value update, dead-time between digits against ghosting, and optional leading-zero blanking.

Parameters:
- N_DIGITS, 4, number of digits scanned (≥2).
- DIV, 27000, CLK cycles each digit is lit (≥1).
- GAP, 64, CLK cycles with all digits off between digits (≥1).
- DIG_ACTIVE_LOW, 1, 1 = DIG enables active-low, 0 = active-high.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous reset, active-high
- LOAD  in  1  single-cycle strobe; capture VALUE into the pending register
- VALUE  in  4*N_DIGITS  hex digits; digit 0 = VALUE[3:0] (least significant)
- LZ_EN  in  1  1 = blank leading zeros
- NIBBLE  out  4  digit code to the decoder
- SEG_BLANK  out  1  1 = force all segments off
- DIG  out  N_DIGITS  per-digit enable, polarity per DIG_ACTIVE_LOW
- FRAME  out  1  one-cycle pulse when a full scan completes
- PENDING  out  1  1 = loaded value not yet shown

Behaviour:
- One clock; reset is synchronous and active-high. All state and outputs are registered.
- Reset values:
  - NIBBLE=0, SEG_BLANK=1, DIG=all inactive, FRAME=0, PENDING=0.
  - Display register = 0, pending register = 0, digit index = 0, state = SHOW, cycle counter = 0.
- RST asserted mid-operation discards the pending value and any scan in progress.
- States:
  - SHOW: counter runs 0..DIV-1. At DIV-1, go to GAP and clear the counter.
  - GAP: counter runs 0..GAP-1. At GAP-1:
    - Advance the index. At index N_DIGITS-1, wrap to 0.
    - Go to SHOW and clear the counter.
- Outputs track state with 1-cycle latency.
  - In SHOW: DIG has only bit[index] active, NIBBLE = display digit[index], SEG_BLANK = blank(index).
  - In GAP: DIG all inactive, SEG_BLANK=1, NIBBLE holds its last value.
- The first cycle after RST deasserts is SHOW, index 0. Digit 0 becomes visible on the outputs one cycle later.
- Per-digit period is DIV+GAP cycles. Frame period is N_DIGITS*(DIV+GAP) cycles.
- Leading-zero blanking:
  - blank(i)=1 iff LZ_EN=1, i>0, and digits i..N_DIGITS-1 of the display register are all 0.
  - Digit 0 is never blanked, so value 0 shows a single "0".
- Update:
  - LOAD=1 copies VALUE into the pending register and sets PENDING.
  - Commit happens at the index wrap (GAP end at index N_DIGITS-1): display ← pending, PENDING cleared, FRAME pulses in the same registered cycle.
  - Without pending data, FRAME still pulses and the display register is unchanged.
- Boundary cases:
  - LOAD in the exact commit cycle: VALUE goes directly to the display register and PENDING stays 0. New data wins.
  - Multiple LOADs within one frame: the last one wins.
  - LOAD has no effect on the scan timing.
- VALUE is sampled only when LOAD=1 and may change at any other time.
- LZ_EN is sampled live every cycle.

Test Plan:
1. N_DIGITS=4, DIV=4, GAP=2. Release reset with no LOAD. → DIG cycles 0→1→2→3. Each digit is active for 4 cycles with a 2-cycle all-off gap. FRAME pulses every 24 cycles. NIBBLE=0 throughout.
2. LOAD with VALUE=16'h1A3F mid-frame. → PENDING=1 until the wrap. From the next frame, NIBBLE reads F, 3, A, 1 on digits 0..3. No digit shows the new value before FRAME.
3. LZ_EN=1, VALUE=16'h0050 loaded. → Digits 0 and 1 are shown (0, 5) with SEG_BLANK=0. Digits 2 and 3 have SEG_BLANK=1 while their DIG is still scanned. Then VALUE=0 → only digit 0 unblanked.
4. LOAD asserted in the exact commit cycle with VALUE=16'h1234, after an earlier LOAD of 16'hFFFF. → The display shows 1234 and PENDING=0 after the commit.
5. RST asserted in the middle of digit 2 with PENDING=1. → Next cycle all outputs are at reset values and PENDING=0. The scan restarts at digit 0 showing 0.
6. DIG_ACTIVE_LOW=0 rerun of scenario 1. → DIG is one-hot active-high and all-zero during gaps and reset.
